// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer master: valid/ready request in, one-cycle response pulse out.
// Define WBM_TIMEOUT_EN to abort a bus cycle with rsp_err_o after TIMEOUT_CYCLES without ack_i.
module wb_master_bridge #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  // Core-side request/response
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW/8-1:0] req_sel_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  // Wishbone initiator
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [DW/8-1:0] sel_o,
  output logic [AW-1:0]   adr_o,
  output logic [DW-1:0]   dat_o,
  input  logic [DW-1:0]   dat_i,
  input  logic            ack_i
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e state_q;

  assign req_ready_o = (state_q == StIdle);

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Last BUS cycle that may still complete normally; no ack by then means abort.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] tmo_cnt_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign rsp_err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      sel_o       <= '0;
      adr_o       <= '0;
      dat_o       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
`ifdef WBM_TIMEOUT_EN
      rsp_err_o   <= 1'b0;
      tmo_cnt_q   <= '0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      rsp_err_o   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_o    <= req_we_i;
            adr_o   <= req_addr_i;
            sel_o   <= req_sel_i;
            dat_o   <= req_wdata_i;
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            state_q <= StBus;
`ifdef WBM_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end
        end
        StBus: begin
          // ack wins over a simultaneous timeout; leaving BUS makes a level ack harmless
          if (ack_i) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            rsp_valid_o <= 1'b1;
            state_q     <= StResp;
            if (!we_o) begin
              rsp_rdata_o <= dat_i;
            end
          end
`ifdef WBM_TIMEOUT_EN
          else if (tmo_cnt_q == CntLast) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            state_q     <= StResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized bench for wb_master_bridge: behavioural Wishbone slave plus a transaction-level
// reference model predicting response data, error and latency for every accepted request.
module tb_wb_master_bridge;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_sel = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r = '0;
  logic        ack = 1'b0;

  wb_master_bridge #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_sel_i   (req_sel),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .cyc_o       (cyc),
    .stb_o       (stb),
    .we_o        (we),
    .sel_o       (sel),
    .adr_o       (adr),
    .dat_o       (dat_w),
    .dat_i       (dat_r),
    .ack_i       (ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc_n = 0;
  int unsigned cyc_hi = 0;
  exp_t        exp_q[$];
  int unsigned acc_q[$];
  int unsigned rsp_cyc_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] slv_mem[64];
  logic [31:0] last_rdata = '0;
  int unsigned ack_delay = 1;
  int unsigned ack_hold = 1;
  bit          never_ack = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Transaction-level prediction made at acceptance time
  function automatic void model_push(input logic w, input logic [31:0] a, input logic [3:0] s,
                                     input logic [31:0] wd);
    exp_t       e;
    logic [5:0] idx;
    bit         timeout;
    idx = a[7:2];
`ifdef WBM_TIMEOUT_EN
    timeout = never_ack || (ack_delay + 1 > TMO);
`else
    timeout = 1'b0;
`endif
    e.we = w; e.addr = a; e.sel = s; e.wdata = wd;
    e.err = timeout;
    e.lat = timeout ? TMO : ack_delay + 1;
    if (!timeout) begin
      if (w) ref_mem[idx] = merge(ref_mem[idx], wd, s);
      else   last_rdata = ref_mem[idx];
    end
    e.rdata = last_rdata;
    exp_q.push_back(e);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Slave: acks ack_delay cycles after strobe is first seen, holds ack for ack_hold cycles
  initial begin
    int unsigned stb_cnt = 0;
    int unsigned ack_left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_left > 0) begin
        ack_left--;
        if (ack_left == 0) begin
          ack = 1'b0;
          dat_r = $urandom;
        end
      end else if (stb && !never_ack) begin
        stb_cnt++;
        if (stb_cnt > ack_delay) begin
          ack = 1'b1;
          ack_left = ack_hold;
          stb_cnt = 0;
          if (we) slv_mem[adr[7:2]] = merge(slv_mem[adr[7:2]], dat_w, sel);
          else    dat_r = slv_mem[adr[7:2]];
        end
      end else begin
        stb_cnt = 0;
      end
    end
  end

  // Protocol monitor and response scoreboard
  initial forever begin
    exp_t        e;
    int unsigned a;
    @(negedge clk);
    if (!rst_n) begin
      cyc_hi = 0;
      continue;
    end
    check_eq("ready_only_idle", 32'(req_ready), 32'(!(cyc || rsp_valid)));
    check_eq("stb_eq_cyc", 32'(stb), 32'(cyc));
    if (cyc) begin
      cyc_hi++;
      if (exp_q.size() == 0) begin
        check_eq("cyc_without_req", 32'(cyc), 32'd0);
      end else begin
        check_eq("bus_adr", adr, exp_q[0].addr);
        check_eq("bus_we", 32'(we), 32'(exp_q[0].we));
        check_eq("bus_sel", 32'(sel), 32'(exp_q[0].sel));
        check_eq("bus_dat", dat_w, exp_q[0].wdata);
      end
    end
    if (rsp_valid) begin
      rsp_cyc_q.push_back(cyc_n);
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        check_eq("spurious_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
        check_eq("rsp_latency", cyc_n - a, e.lat);
        check_eq("cyc_hi_cycles", cyc_hi, e.lat);
      end
      cyc_hi = 0;
    end
    if (req_valid && req_ready) acc_q.push_back(cyc_n + 1);
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, input bit hold);
    int guard = 0;
    @(posedge clk);
    #2;
    req_valid = 1'b1; req_we = w; req_addr = a; req_sel = s; req_wdata = wd;
    while (!req_ready && guard < 100) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 100) begin
      check_eq("accept_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    model_push(w, a, s, wd);
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (exp_q.size() != 0 && guard < 200);
    if (exp_q.size() != 0) begin
      check_eq("rsp_wait", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'hC0DE0000 | 32'(i);
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[16] = 32'hDEADBEEF;
    slv_mem[16] = 32'hDEADBEEF;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_cyc", 32'(cyc), 32'd0);
    check_eq("rst_stb", 32'(stb), 32'd0);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_sel", 32'(sel), 32'd0);
    check_eq("rst_adr", adr, 32'd0);
    check_eq("rst_dat", dat_w, 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    // Single read from a one-cycle-ack slave
    send(1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    wait_idle();
    check_eq("read_hold", rsp_rdata, 32'hDEADBEEF);

    // Partial write then readback
    send(1'b1, 32'h44, 4'b0011, 32'h12345678, 1'b0);
    wait_idle();
    check_eq("write_keeps_rdata", rsp_rdata, 32'hDEADBEEF);
    send(1'b0, 32'h44, 4'hF, 32'h0, 1'b0);
    wait_idle();
    check_eq("wr_readback", rsp_rdata, 32'hC0DE5678);

    // Level ack held three cycles: exactly one response
    n = rsp_cyc_q.size();
    ack_hold = 3;
    send(1'b0, 32'h48, 4'hF, 32'h0, 1'b0);
    wait_idle();
    repeat (6) @(negedge clk);
    check_eq("level_ack_one_rsp", 32'(rsp_cyc_q.size() - n), 32'd1);
    ack_hold = 1;

    // Four back-to-back requests with valid held high
    rsp_cyc_q.delete();
    send(1'b0, 32'h50, 4'hF, 32'h0, 1'b1);
    send(1'b1, 32'h54, 4'b1100, 32'hAABBCCDD, 1'b1);
    send(1'b0, 32'h54, 4'hF, 32'h0, 1'b1);
    send(1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    wait_idle();
    check_eq("b2b_count", 32'(rsp_cyc_q.size()), 32'd4);
    for (int i = 1; i < rsp_cyc_q.size(); i++)
      check_eq("b2b_interval", rsp_cyc_q[i] - rsp_cyc_q[i-1], 32'd4);

`ifdef WBM_TIMEOUT_EN
    never_ack = 1'b1;
    send(1'b0, 32'h4C, 4'hF, 32'h0, 1'b0);
    wait_idle();
    never_ack = 1'b0;
    ack_delay = 7;
    send(1'b0, 32'h4C, 4'hF, 32'h0, 1'b0);
    wait_idle();
    ack_delay = 8;
    send(1'b1, 32'h4C, 4'hF, 32'h55555555, 1'b0);
    wait_idle();
    ack_delay = 1;
    send(1'b0, 32'h4C, 4'hF, 32'h0, 1'b0);
    wait_idle();
`else
    ack_delay = 40;
    send(1'b0, 32'h4C, 4'hF, 32'h0, 1'b0);
    wait_idle();
    ack_delay = 1;
`endif

    // Reset asserted mid-transfer
    never_ack = 1'b1;
    send(1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_cyc", 32'(cyc), 32'd0);
    check_eq("midrst_stb", 32'(stb), 32'd0);
    check_eq("midrst_adr", adr, 32'd0);
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    acc_q.delete();
    never_ack = 1'b0;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_rdata", rsp_rdata, 32'd0);
    repeat (4) @(negedge clk);
    send(1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    wait_idle();
    check_eq("post_rst_read", rsp_rdata, 32'hDEADBEEF);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      wait_idle();
      ack_delay = $urandom_range(0, 3);
      ack_hold  = $urandom_range(1, 2);
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      send(1'($urandom), a, 4'($urandom), $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
